mac_tx_scheduler: RTL and testbench

MAC_TX_SCHEDULER -- requirements
Module: mac_tx_scheduler

---
 rtl/mac_tx_scheduler.sv | 162 ++++++++++++++++
 tb/tb_mac_tx_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_scheduler.sv
// Round-robin MAC TX frame scheduler; MAC_TX_SCHED_TIMEOUT_EN adds a done-watchdog.
// Latency: i_req seen in IDLE -> o_start 1 clock later; the generator throttles via i_done.
module mac_tx_scheduler #(
    parameter int N_REQ            = 4,
    parameter int PAYLOAD_MAX_SIZE = 1500,
    parameter int IFG_CYCLES       = 12,
    parameter int TIMEOUT_CYCLES   = 4096
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [N_REQ*48-1:0]   i_dest_address,
    input  logic [N_REQ*16-1:0]   i_eth_type,
    input  logic [N_REQ*16-1:0]   i_payload_length,
    input  logic                  i_done,
    output logic                  o_start,
    output logic [47:0]           o_dest_address,
    output logic [15:0]           o_eth_type,
    output logic [15:0]           o_payload_length,
    output logic [N_REQ-1:0]      o_grant,
    output logic [N_REQ-1:0]      o_ack,
    output logic                  o_busy,
    output logic                  o_timeout
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int IW = $clog2(IFG_CYCLES + 1);

    if (N_REQ < 2 || N_REQ > 8 || IFG_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mac_tx_scheduler: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, IFG} state_t;

    state_t            r_state;
    logic [PW-1:0]     r_rr_ptr;
    logic [PW-1:0]     r_owner;
    logic [IW-1:0]     r_ifg_cnt;
    logic              r_start;
    logic [N_REQ-1:0]  r_grant;
    logic [N_REQ-1:0]  r_ack;
    logic              r_busy;
    logic [47:0]       r_dest;
    logic [15:0]       r_type;
    logic [15:0]       r_len;

    logic              w_found;
    logic [PW-1:0]     w_win;
    logic [15:0]       w_len_in;
    logic [15:0]       w_len_clamped;
    logic [PW-1:0]     w_next_ptr;

    // Search upward from the pointer with wrap; first active requester wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && i_req[(int'(r_rr_ptr) + i) % N_REQ]) begin
                w_found = 1'b1;
                w_win   = PW'((int'(r_rr_ptr) + i) % N_REQ);
            end
        end
    end

    assign w_len_in      = i_payload_length[int'(w_win)*16 +: 16];
    assign w_len_clamped = (w_len_in > 16'(PAYLOAD_MAX_SIZE)) ? 16'(PAYLOAD_MAX_SIZE) : w_len_in;
    assign w_next_ptr    = (r_owner == PW'(N_REQ - 1)) ? '0 : r_owner + PW'(1);

`ifdef MAC_TX_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_wd_cnt;
    logic          r_timeout;
    assign o_timeout = r_timeout;
`else
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_rr_ptr  <= '0;
            r_owner   <= '0;
            r_ifg_cnt <= '0;
            r_start   <= 1'b0;
            r_grant   <= '0;
            r_ack     <= '0;
            r_busy    <= 1'b0;
            r_dest    <= '0;
            r_type    <= '0;
            r_len     <= '0;
`ifdef MAC_TX_SCHED_TIMEOUT_EN
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_start <= 1'b0;
            r_ack   <= '0;
`ifdef MAC_TX_SCHED_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant <= N_REQ'(1) << w_win;
                        r_owner <= w_win;
                        r_dest  <= i_dest_address[int'(w_win)*48 +: 48];
                        r_type  <= i_eth_type[int'(w_win)*16 +: 16];
                        r_len   <= w_len_clamped;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
`ifdef MAC_TX_SCHED_TIMEOUT_EN
                    r_wd_cnt <= '0;
`endif
                    r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // A done coinciding with the watchdog limit still completes normally.
                    if (i_done) begin
                        r_ack     <= r_grant;
                        r_rr_ptr  <= w_next_ptr;
                        r_grant   <= '0;
                        r_ifg_cnt <= '0;
                        r_state   <= IFG;
                    end
`ifdef MAC_TX_SCHED_TIMEOUT_EN
                    else if (r_wd_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_timeout <= 1'b1;
                        r_rr_ptr  <= w_next_ptr;
                        r_grant   <= '0;
                        r_ifg_cnt <= '0;
                        r_state   <= IFG;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + TW'(1);
                    end
`endif
                end
                IFG: begin
                    if (r_ifg_cnt == IW'(IFG_CYCLES - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_ifg_cnt <= r_ifg_cnt + IW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_start          = r_start;
    assign o_grant          = r_grant;
    assign o_ack            = r_ack;
    assign o_busy           = r_busy;
    assign o_dest_address   = r_dest;
    assign o_eth_type       = r_type;
    assign o_payload_length = r_len;

endmodule

// File: tb/tb_mac_tx_scheduler.sv
// Self-checking bench for mac_tx_scheduler: vector table, hand sequences and randomized frames.
module tb_mac_tx_scheduler;

    localparam int IFG  = 12;
    localparam int PMAX = 1500;
`ifdef MAC_TX_SCHED_TIMEOUT_EN
    localparam int MAX_DLY = 16;
`else
    localparam int MAX_DLY = 20;
`endif

    logic         clk = 1'b0;
    logic         i_rst;
    logic [3:0]   i_req;
    logic [191:0] i_dest_address;
    logic [63:0]  i_eth_type;
    logic [63:0]  i_payload_length;
    logic         i_done;
    logic         o_start;
    logic [47:0]  o_dest_address;
    logic [15:0]  o_eth_type;
    logic [15:0]  o_payload_length;
    logic [3:0]   o_grant;
    logic [3:0]   o_ack;
    logic         o_busy;
    logic         o_timeout;

    logic [47:0] da [4];
    logic [15:0] et [4];
    logic [15:0] pl [4];

    assign i_dest_address   = {da[3], da[2], da[1], da[0]};
    assign i_eth_type       = {et[3], et[2], et[1], et[0]};
    assign i_payload_length = {pl[3], pl[2], pl[1], pl[0]};

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mac_tx_scheduler #(
        .N_REQ(4), .PAYLOAD_MAX_SIZE(PMAX), .IFG_CYCLES(IFG), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .i_rst(i_rst), .i_req(i_req), .i_dest_address(i_dest_address),
        .i_eth_type(i_eth_type), .i_payload_length(i_payload_length), .i_done(i_done),
        .o_start(o_start), .o_dest_address(o_dest_address), .o_eth_type(o_eth_type),
        .o_payload_length(o_payload_length), .o_grant(o_grant), .o_ack(o_ack),
        .o_busy(o_busy), .o_timeout(o_timeout)
    );

    typedef struct {
        logic [3:0]  req;
        logic [15:0] len;
        int          exp_idx;
        logic [15:0] exp_len;
        int          dly;
        bit          glitch;
        bit          scramble;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_start"}, o_start, 0);
        chk({nm, "_grant"}, o_grant, 0);
        chk({nm, "_ack"}, o_ack, 0);
        chk({nm, "_busy"}, o_busy, 0);
        chk({nm, "_timeout"}, o_timeout, 0);
        chk({nm, "_dest"}, o_dest_address, 0);
        chk({nm, "_type"}, o_eth_type, 0);
        chk({nm, "_len"}, o_payload_length, 0);
    endtask

    // Remaining IFG cycles after the completion cycle, then the IDLE cycle.
    task automatic finish_ifg(input bit glitch);
        for (int k = 0; k < IFG - 1; k++) begin
            if (glitch) i_done = (k == 4);
            step();
            chk("ifg_busy", o_busy, 1);
            chk("ifg_grant", o_grant, 0);
            chk("ifg_start", o_start, 0);
            chk("ifg_ack", o_ack, 0);
        end
        i_done = 1'b0;
        step();
        chk("idle_busy", o_busy, 0);
        chk("idle_start", o_start, 0);
        chk("idle_grant", o_grant, 0);
    endtask

    task automatic randomize_fields();
        for (int k = 0; k < 4; k++) begin
            da[k] = {16'($urandom()), 32'($urandom())};
            et[k] = 16'($urandom());
            pl[k] = 16'($urandom());
        end
    endtask

    // Called with the DUT in IDLE; ends observing the next IDLE cycle.
    task automatic run_frame(input logic [3:0] req, input int exp_idx, input logic [15:0] exp_len,
                             input int dly, input bit glitch, input bit scramble);
        logic [47:0] e_da;
        logic [15:0] e_et;
        logic [3:0]  e_gnt;
        e_da  = da[exp_idx];
        e_et  = et[exp_idx];
        e_gnt = 4'(1 << exp_idx);
        i_req  = req;
        i_done = glitch;
        step();
        chk("start_pulse", o_start, 1);
        chk("grant", o_grant, e_gnt);
        chk("dest", o_dest_address, e_da);
        chk("type", o_eth_type, e_et);
        chk("len", o_payload_length, exp_len);
        chk("busy", o_busy, 1);
        chk("start_ack", o_ack, 0);
        step();
        i_done = 1'b0;
        chk("start_one_cycle", o_start, 0);
        chk("wait_grant", o_grant, e_gnt);
        chk("wait_ack", o_ack, 0);
        if (scramble) begin
            randomize_fields();
            i_req = 4'($urandom_range(0, 15));
        end
        for (int k = 2; k <= dly; k++) begin
            step();
            chk("hold_grant", o_grant, e_gnt);
            chk("hold_dest", o_dest_address, e_da);
            chk("hold_type", o_eth_type, e_et);
            chk("hold_len", o_payload_length, exp_len);
            chk("hold_ack", o_ack, 0);
            chk("hold_start", o_start, 0);
        end
        i_done = 1'b1;
        step();
        i_done = 1'b0;
        chk("ack", o_ack, e_gnt);
        chk("ack_grant_clr", o_grant, 0);
        chk("ack_busy", o_busy, 1);
        chk("ack_timeout", o_timeout, 0);
        chk("ack_dest", o_dest_address, e_da);
        finish_ifg(glitch);
    endtask

    function automatic int first_from(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++) if (r[(p + i) % 4]) return (p + i) % 4;
        return 0;
    endfunction

    task automatic do_reset();
        i_rst = 1'b1;
        #1;
        chk_zero("reset_async");
        step();
        chk_zero("reset_held");
        i_rst = 1'b0;
    endtask

    vec_t tbl [6];
    int   mptr;

    initial begin
        tbl[0] = '{4'b0001, 16'd64,    0, 16'd64,   MAX_DLY, 1'b0, 1'b0};
        tbl[1] = '{4'b1111, 16'd2000,  1, 16'd1500, 5,       1'b1, 1'b0};
        tbl[2] = '{4'b0001, 16'd0,     0, 16'd0,    1,       1'b0, 1'b1};
        tbl[3] = '{4'b1001, 16'd1500,  3, 16'd1500, 7,       1'b0, 1'b1};
        tbl[4] = '{4'b0110, 16'd1501,  1, 16'd1500, 2,       1'b1, 1'b0};
        tbl[5] = '{4'b0011, 16'hFFFF,  0, 16'd1500, 9,       1'b0, 0};

        for (int k = 0; k < 4; k++) begin
            da[k] = 48'h0A0B_0C0D_0E00 + 48'(k);
            et[k] = 16'h0800 + 16'(k);
            pl[k] = 16'd64;
        end
        i_req  = 4'b0000;
        i_done = 1'b0;
        i_rst  = 1'b1;
        #1;
        chk_zero("por");
        step();
        step();
        i_rst = 1'b0;
        step();
        chk_zero("idle_after_reset");

        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < 4; k++) pl[k] = tbl[v].len;
            run_frame(tbl[v].req, tbl[v].exp_idx, tbl[v].exp_len, tbl[v].dly,
                      tbl[v].glitch, tbl[v].scramble);
        end

        // Reset mid-frame, then fairness with all four requesting.
        for (int k = 0; k < 4; k++) pl[k] = 16'd100;
        run_frame(4'b0010, 1, 16'd100, 3, 1'b0, 1'b0);
        i_req = 4'b1111;
        step();
        chk("rst_pre_grant", o_grant, 4'b0100);
        step();
        step();
        i_done = 1'b1;
        do_reset();
        i_done = 1'b0;
        run_frame(4'b1111, 0, 16'd100, 3, 1'b0, 1'b0);
        for (int f = 1; f < 8; f++) run_frame(4'b1111, f % 4, 16'd100, 2 + f, 1'b0, 1'b0);

`ifdef MAC_TX_SCHED_TIMEOUT_EN
        i_req = 4'b0011;
        step();
        chk("wd_grant", o_grant, 4'b0001);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("wd_early_timeout", o_timeout, 0);
            chk("wd_early_ack", o_ack, 0);
        end
        step();
        chk("wd_timeout", o_timeout, 1);
        chk("wd_no_ack", o_ack, 0);
        chk("wd_grant_clr", o_grant, 0);
        chk("wd_busy", o_busy, 1);
        finish_ifg(1'b0);
        run_frame(4'b0011, 1, 16'd100, 2, 1'b0, 1'b0);
        i_req = 4'b0001;
        step();
        chk("wd_tie_grant", o_grant, 4'b0001);
        for (int k = 1; k <= 16; k++) step();
        i_done = 1'b1;
        step();
        i_done = 1'b0;
        chk("wd_tie_ack", o_ack, 4'b0001);
        chk("wd_tie_timeout", o_timeout, 0);
        finish_ifg(1'b0);
`else
        i_req = 4'b0001;
        step();
        chk("nowd_grant", o_grant, 4'b0001);
        for (int k = 0; k < 40; k++) begin
            step();
            chk("nowd_timeout", o_timeout, 0);
            chk("nowd_busy", o_busy, 1);
            chk("nowd_ack", o_ack, 0);
        end
        i_done = 1'b1;
        step();
        i_done = 1'b0;
        chk("nowd_ack_late", o_ack, 4'b0001);
        finish_ifg(1'b0);
`endif

        // Randomized frames against a transaction-level round-robin model.
        do_reset();
        mptr = 0;
        for (int f = 0; f < 40; f++) begin
            logic [3:0]  req;
            logic [15:0] elen;
            int          w;
            randomize_fields();
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 4))
                    0:       pl[k] = 16'd0;
                    1:       pl[k] = 16'd1500;
                    2:       pl[k] = 16'd1501;
                    default: pl[k] = 16'($urandom_range(0, 3000));
                endcase
            end
            req  = 4'($urandom_range(1, 15));
            w    = first_from(req, mptr);
            elen = (pl[w] > 16'(PMAX)) ? 16'(PMAX) : pl[w];
            run_frame(req, w, elen, $urandom_range(1, MAX_DLY),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            mptr = (w + 1) % 4;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
